// File: rtl/led_shift_driver_if.sv
// Upstream word handshake for led_shift_driver: the producer (ALU LED register side)
// drives iData/iValid, the driver reports oReady/oBusy.
interface led_shift_driver_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] iData;
  logic                  iValid;
  logic                  oReady;
  logic                  oBusy;

  modport master (output iData, output iValid, input oReady, input oBusy);
  modport slave  (input iData, input iValid, output oReady, output oBusy);
endinterface

// File: rtl/led_shift_driver.sv
// Serialises one word MSB-first onto a 74HC595-style register (DS/SHCP/STCP pins).
// Optional LED_SHIFT_AUTO_UPDATE_EN: send automatically whenever iData differs from the last sent word.
module led_shift_driver #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  led_shift_driver_if.slave   host,
  output logic                oSerialData,
  output logic                oSerialClock,
  output logic                oLatch
);
  localparam int unsigned PHASE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W   = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} stateT;

  stateT                 state, stateNext;
  logic [PHASE_W-1:0]    phase, phaseNext;
  logic [BIT_W-1:0]      bitCnt, bitCntNext;
  logic [DATA_WIDTH-1:0] shiftReg, shiftRegNext;
  logic                  readyNext, busyNext;
  logic                  serialDataNext, serialClockNext, latchNext;
  logic                  phaseDone;
  logic                  startReq;
  logic                  accept;

  assign phaseDone = (phase == PHASE_W'(CLK_DIV - 1));
  assign accept    = (state == IDLE) && startReq;

`ifdef LED_SHIFT_AUTO_UPDATE_EN
  // Request follows the word itself; changes seen while busy collapse onto the latest value.
  logic [DATA_WIDTH-1:0] lastWord;
  logic                  unusedValid;

  assign unusedValid = host.iValid;
  assign startReq    = (host.iData != lastWord);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      lastWord <= '0;
    end else if (accept) begin
      lastWord <= host.iData;
    end
  end
`else
  assign startReq = host.iValid;
`endif

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    stateNext       = state;
    phaseNext       = phase;
    bitCntNext      = bitCnt;
    shiftRegNext    = shiftReg;
    readyNext       = 1'b0;
    busyNext        = 1'b1;
    serialDataNext  = oSerialData;
    serialClockNext = 1'b0;
    latchNext       = 1'b0;

    unique case (state)
      IDLE: begin
        readyNext = 1'b1;
        busyNext  = 1'b0;
        if (accept) begin
          stateNext      = SHIFT_LO;
          shiftRegNext   = host.iData;
          serialDataNext = host.iData[DATA_WIDTH-1];
          phaseNext      = '0;
          bitCntNext     = '0;
          readyNext      = 1'b0;
          busyNext       = 1'b1;
        end
      end

      SHIFT_LO: begin
        if (phaseDone) begin
          stateNext       = SHIFT_HI;
          phaseNext       = '0;
          serialClockNext = 1'b1;
        end else begin
          phaseNext = phase + PHASE_W'(1);
        end
      end

      SHIFT_HI: begin
        serialClockNext = 1'b1;
        if (phaseDone) begin
          phaseNext       = '0;
          serialClockNext = 1'b0;
          if (bitCnt == BIT_W'(DATA_WIDTH - 1)) begin
            stateNext  = LATCH;
            bitCntNext = '0;
            latchNext  = 1'b1;
          end else begin
            // Data moves with the falling shift clock, half a period ahead of the next rise.
            stateNext      = SHIFT_LO;
            shiftRegNext   = shiftReg << 1;
            serialDataNext = shiftRegNext[DATA_WIDTH-1];
            bitCntNext     = bitCnt + BIT_W'(1);
          end
        end else begin
          phaseNext = phase + PHASE_W'(1);
        end
      end

      LATCH: begin
        latchNext = 1'b1;
        if (phaseDone) begin
          stateNext = IDLE;
          phaseNext = '0;
          latchNext = 1'b0;
          readyNext = 1'b1;
          busyNext  = 1'b0;
        end else begin
          phaseNext = phase + PHASE_W'(1);
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      phase        <= '0;
      bitCnt       <= '0;
      shiftReg     <= '0;
      host.oReady  <= 1'b1;
      host.oBusy   <= 1'b0;
      oSerialData  <= 1'b0;
      oSerialClock <= 1'b0;
      oLatch       <= 1'b0;
    end else begin
      state        <= stateNext;
      phase        <= phaseNext;
      bitCnt       <= bitCntNext;
      shiftReg     <= shiftRegNext;
      host.oReady  <= readyNext;
      host.oBusy   <= busyNext;
      oSerialData  <= serialDataNext;
      oSerialClock <= serialClockNext;
      oLatch       <= latchNext;
    end
  end

endmodule

// File: tb/tb_led_shift_driver.sv
// Bench for led_shift_driver: a behavioural 74HC595 (shift stage + display latch) watches the pins
// and each scenario compares the displayed word, pulse counts and transfer length against the rules.
module tb_led_shift_driver;
  localparam int unsigned DW = 8;
`ifdef LED_SHIFT_AUTO_UPDATE_EN
  localparam int unsigned CD = 1;
`else
  localparam int unsigned CD = 4;
`endif
  localparam int XFER = 2 * CD * DW + CD;

  logic Clock = 1'b0;
  logic Reset;
  logic oSerialData, oSerialClock, oLatch;

  int vectors     = 0;
  int miscompares = 0;

  led_shift_driver_if #(.DATA_WIDTH(DW)) host ();

  led_shift_driver #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .host        (host),
    .oSerialData (oSerialData),
    .oSerialClock(oSerialClock),
    .oLatch      (oLatch)
  );

  always #5 Clock = ~Clock;

  // External shift register model, sampled on the falling system clock.
  logic [DW-1:0] sr595      = '0;
  logic [DW-1:0] disp595    = '0;
  logic          prevSclk   = 1'b0;
  logic          prevLatch  = 1'b0;
  logic          prevData   = 1'b0;
  int            dataAge    = 1000;
  int            sclkRises  = 0;
  int            latchPulses = 0;
  int            latchHigh  = 0;
  int            setupViol  = 0;

  always @(negedge Clock) begin
    if (oSerialData !== prevData) dataAge = 0;
    else dataAge++;
    if (oSerialClock && !prevSclk) begin
      sr595 = {sr595[DW-2:0], oSerialData};
      sclkRises++;
      if (dataAge < CD) setupViol++;
    end
    if (oLatch && !prevLatch) begin
      disp595 = sr595;
      latchPulses++;
    end
    if (oLatch) latchHigh++;
    prevSclk  = oSerialClock;
    prevLatch = oLatch;
    prevData  = oSerialData;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic wait_ready(output int k);
    k = 0;
    while (host.oReady !== 1'b1 && k < 1000) begin
      tick(1);
      k++;
    end
  endtask

  task automatic test_reset();
    host.iData  = 8'hA5;
    host.iValid = 1'b1;
    tick(1);
    host.iValid = 1'b0;
    tick(CD);
    #2;
    Reset = 1'b1;
    #1;
    vectors++;
    if (host.oReady !== 1'b1) begin
      miscompares++; $display("FAIL reset.oReady got %b exp 1", host.oReady);
    end
    vectors++;
    if (host.oBusy !== 1'b0) begin
      miscompares++; $display("FAIL reset.oBusy got %b exp 0", host.oBusy);
    end
    vectors++;
    if (oSerialData !== 1'b0) begin
      miscompares++; $display("FAIL reset.oSerialData got %b exp 0", oSerialData);
    end
    vectors++;
    if (oSerialClock !== 1'b0) begin
      miscompares++; $display("FAIL reset.oSerialClock got %b exp 0", oSerialClock);
    end
    vectors++;
    if (oLatch !== 1'b0) begin
      miscompares++; $display("FAIL reset.oLatch got %b exp 0", oLatch);
    end
    host.iData = '0;
    tick(2);
    Reset = 1'b0;
    tick(2);
  endtask

`ifndef LED_SHIFT_AUTO_UPDATE_EN
  task automatic test_single(input logic [DW-1:0] word);
    int r0, p0, h0, v0, k;
    r0 = sclkRises; p0 = latchPulses; h0 = latchHigh; v0 = setupViol;
    host.iData  = word;
    host.iValid = 1'b1;
    tick(1);
    host.iValid = 1'b0;
    host.iData  = DW'($urandom);
    vectors++;
    if (host.oBusy !== 1'b1 || host.oReady !== 1'b0) begin
      miscompares++; $display("FAIL single.accept word=%h busy=%b ready=%b exp busy=1 ready=0", word, host.oBusy, host.oReady);
    end
    vectors++;
    if (oSerialData !== word[DW-1]) begin
      miscompares++; $display("FAIL single.firstBit word=%h got %b exp %b", word, oSerialData, word[DW-1]);
    end
    wait_ready(k);
    vectors++;
    if (k != XFER) begin
      miscompares++; $display("FAIL single.length word=%h got %0d exp %0d", word, k, XFER);
    end
    vectors++;
    if (disp595 !== word) begin
      miscompares++; $display("FAIL single.display got %h exp %h", disp595, word);
    end
    vectors++;
    if (sclkRises - r0 != DW) begin
      miscompares++; $display("FAIL single.sclkRises word=%h got %0d exp %0d", word, sclkRises - r0, DW);
    end
    vectors++;
    if (latchPulses - p0 != 1 || latchHigh - h0 != CD) begin
      miscompares++; $display("FAIL single.latch word=%h pulses %0d high %0d exp 1 and %0d", word, latchPulses - p0, latchHigh - h0, CD);
    end
    vectors++;
    if (setupViol != v0) begin
      miscompares++; $display("FAIL single.setup word=%h got %0d late data changes exp 0", word, setupViol - v0);
    end
  endtask

  task automatic test_back_to_back();
    int r0, p0, k;
    r0 = sclkRises; p0 = latchPulses;
    host.iData  = 8'h01;
    host.iValid = 1'b1;
    tick(1);
    host.iData = 8'h80;
    wait_ready(k);
    vectors++;
    if (k != XFER) begin
      miscompares++; $display("FAIL b2b.firstLength got %0d exp %0d", k, XFER);
    end
    tick(1);
    vectors++;
    if (host.oReady !== 1'b0) begin
      miscompares++; $display("FAIL b2b.gap second word not accepted after one idle cycle, ready=%b", host.oReady);
    end
    host.iValid = 1'b0;
    vectors++;
    if (disp595 !== 8'h01) begin
      miscompares++; $display("FAIL b2b.firstDisplay got %h exp 01", disp595);
    end
    wait_ready(k);
    vectors++;
    if (k != XFER) begin
      miscompares++; $display("FAIL b2b.secondLength got %0d exp %0d", k, XFER);
    end
    tick(6);
    vectors++;
    if (disp595 !== 8'h80) begin
      miscompares++; $display("FAIL b2b.secondDisplay got %h exp 80", disp595);
    end
    vectors++;
    if (latchPulses - p0 != 2 || sclkRises - r0 != 2 * DW) begin
      miscompares++; $display("FAIL b2b.counts pulses %0d rises %0d exp 2 and %0d", latchPulses - p0, sclkRises - r0, 2 * DW);
    end
  endtask

  task automatic test_busy_ignore();
    int p0, k;
    p0 = latchPulses;
    host.iData  = 8'h00;
    host.iValid = 1'b1;
    tick(1);
    host.iValid = 1'b0;
    tick(9);
    host.iData  = 8'hFF;
    host.iValid = 1'b1;
    tick(1);
    host.iValid = 1'b0;
    wait_ready(k);
    vectors++;
    if (k != XFER - 10) begin
      miscompares++; $display("FAIL busy.length got %0d exp %0d", k, XFER - 10);
    end
    tick(2 * XFER);
    vectors++;
    if (disp595 !== 8'h00) begin
      miscompares++; $display("FAIL busy.display got %h exp 00", disp595);
    end
    vectors++;
    if (latchPulses - p0 != 1 || host.oReady !== 1'b1) begin
      miscompares++; $display("FAIL busy.noSecond pulses %0d ready %b exp 1 and 1", latchPulses - p0, host.oReady);
    end
  endtask

  task automatic test_abort();
    int p0;
    logic [DW-1:0] shown;
    shown = disp595;
    p0 = latchPulses;
    host.iData  = 8'h3C;
    host.iValid = 1'b1;
    tick(1);
    host.iValid = 1'b0;
    tick(29);
    Reset = 1'b1;
    #1;
    vectors++;
    if (host.oReady !== 1'b1 || oSerialClock !== 1'b0 || oLatch !== 1'b0) begin
      miscompares++; $display("FAIL abort.outputs ready %b sclk %b latch %b exp 1 0 0", host.oReady, oSerialClock, oLatch);
    end
    tick(2);
    Reset = 1'b0;
    tick(XFER);
    vectors++;
    if (latchPulses != p0 || disp595 !== shown) begin
      miscompares++; $display("FAIL abort.noLatch pulses %0d display %h exp %0d and %h", latchPulses, disp595, p0, shown);
    end
    test_single(8'hC3);
  endtask

  task automatic test_random();
    logic [DW-1:0] w;
    for (int i = 0; i < 6; i++) begin
      w = DW'($urandom);
      tick(int'($urandom_range(0, 3)));
      test_single(w);
    end
  endtask
`else
  task automatic test_auto();
    int r0, p0, k, k2;
    r0 = sclkRises; p0 = latchPulses;
    host.iValid = 1'b0;
    host.iData  = 8'h00;
    tick(3);
    vectors++;
    if (host.oReady !== 1'b1) begin
      miscompares++; $display("FAIL auto.idleOnZero ready %b exp 1", host.oReady);
    end
    host.iData = 8'h12;
    tick(1);
    vectors++;
    if (host.oReady !== 1'b0) begin
      miscompares++; $display("FAIL auto.start ready %b exp 0", host.oReady);
    end
    tick(3);
    host.iData = 8'h34;
    tick(3);
    host.iData = 8'h56;
    wait_ready(k2);
    k = 6 + k2;
    vectors++;
    if (k != XFER) begin
      miscompares++; $display("FAIL auto.length got %0d exp %0d", k, XFER);
    end
    vectors++;
    if (disp595 !== 8'h12) begin
      miscompares++; $display("FAIL auto.firstDisplay got %h exp 12", disp595);
    end
    tick(1);
    vectors++;
    if (host.oReady !== 1'b0) begin
      miscompares++; $display("FAIL auto.pendingStart ready %b exp 0", host.oReady);
    end
    wait_ready(k);
    vectors++;
    if (k != XFER) begin
      miscompares++; $display("FAIL auto.secondLength got %0d exp %0d", k, XFER);
    end
    host.iValid = 1'b1;
    tick(3 * XFER);
    vectors++;
    if (disp595 !== 8'h56) begin
      miscompares++; $display("FAIL auto.latestDisplay got %h exp 56", disp595);
    end
    vectors++;
    if (latchPulses - p0 != 2 || sclkRises - r0 != 2 * DW || host.oReady !== 1'b1) begin
      miscompares++; $display("FAIL auto.counts pulses %0d rises %0d ready %b exp 2 %0d 1", latchPulses - p0, sclkRises - r0, host.oReady);
    end
    host.iValid = 1'b0;
  endtask
`endif

  initial begin
    Reset       = 1'b1;
    host.iData  = '0;
    host.iValid = 1'b0;
    tick(3);
    Reset = 1'b0;
    tick(2);
    test_reset();
`ifndef LED_SHIFT_AUTO_UPDATE_EN
    test_single(8'hA5);
    test_back_to_back();
    test_busy_ignore();
    test_abort();
    test_random();
`else
    test_auto();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog bench did not finish, got timeout exp completion");
    $fatal(1);
  end

endmodule
